// File: rtl/serial_pkg.sv
// Shared definitions for the accumulator serial link (serializer and deserializer).
// Holds the receiver state encoding, the frame-length helper and the bit-counter
// width function so both ends of the link size their counters identically.
package serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_e;

  localparam int ACC_DATA_WIDTH_DEF = 32;

  // A frame carries the SA word followed by the CML word.
  function automatic int frame_bits(input int data_width);
    return 2 * data_width;
  endfunction

  // One extra bit over the index width so the counter can represent FRAME_BITS.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(2 * data_width) + 1;
  endfunction

  localparam int FRAME_BITS = frame_bits(ACC_DATA_WIDTH_DEF);

endpackage

// File: rtl/deser_shift_core.sv
// Bit counter and frame assembly register for the serial deserializer.
// frameData presents the frame including the bit on the line this cycle, so the
// parent can capture a complete frame on the same edge its last bit is sampled.
module deser_shift_core
  import serial_pkg::*;
#(
  parameter int ACC_DATA_WIDTH = 32
) (
  input  logic                                    serialClk,
  input  logic                                    reset,
  input  logic                                    serialStart,
  input  logic                                    serialIn,
  output logic [frame_bits(ACC_DATA_WIDTH)-1:0]   frameData,
  output logic                                    frameDone,
  output logic                                    frameRestart,
  output logic                                    busy
);

  localparam int FB = frame_bits(ACC_DATA_WIDTH);
  localparam int CW = bit_cnt_width(ACC_DATA_WIDTH);
  localparam int IW = $clog2(FB);

  deser_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FB-1:0]   frame_q, frame_d;

  // State, counter and frame register.
  always_ff @(posedge serialClk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Next-state: start a frame, shift bits in by index, detect completion/restart.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    frameDone    = 1'b0;
    frameRestart = 1'b0;
    case (state_q)
      IDLE: begin
        if (serialStart) begin
          frame_d    = '0;
          frame_d[0] = serialIn;
          cnt_d      = CW'(1);
          state_d    = RECV;
        end
      end
      RECV: begin
        if (serialStart) begin
          // A start mid-frame abandons the partial frame and begins a new one.
          frameRestart = 1'b1;
          frame_d      = '0;
          frame_d[0]   = serialIn;
          cnt_d        = CW'(1);
        end else begin
          frame_d[cnt_q[IW-1:0]] = serialIn;
          if (cnt_q == CW'(FB - 1)) begin
            frameDone = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign frameData = frame_d;
  assign busy      = (state_q == RECV);

endmodule

// File: rtl/serial_deserializer.sv
// Serial deserializer: rebuilds SA/CML word pairs from the accumulator serial link
// and presents them on a one-deep valid/ready output register, with framing-error
// and overrun pulses. Optional error counter enabled by DESER_ERR_CNT_EN.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int ACC_DATA_WIDTH = 32
) (
  input  logic                      serialClk,
  input  logic                      reset,
  input  logic                      serialStart,
  input  logic                      serialIn,
  input  logic                      outReady,
  output logic                      outValid,
  output logic [ACC_DATA_WIDTH-1:0] outDataSA,
  output logic [ACC_DATA_WIDTH-1:0] outDataCML,
  output logic                      frameError,
  output logic                      overrun,
  output logic                      busy
`ifdef DESER_ERR_CNT_EN
  ,
  output logic [15:0]               errCount,
  input  logic                      errCountClr
`endif
);

  localparam int FB = frame_bits(ACC_DATA_WIDTH);

  logic [FB-1:0]             frame_data;
  logic                      frame_done;
  logic                      frame_restart;

  logic                      outValid_q, outValid_d;
  logic [ACC_DATA_WIDTH-1:0] sa_q, sa_d;
  logic [ACC_DATA_WIDTH-1:0] cml_q, cml_d;
  logic                      frameError_q, frameError_d;
  logic                      overrun_q, overrun_d;

  deser_shift_core #(
    .ACC_DATA_WIDTH (ACC_DATA_WIDTH)
  ) u_core (
    .serialClk    (serialClk),
    .reset        (reset),
    .serialStart  (serialStart),
    .serialIn     (serialIn),
    .frameData    (frame_data),
    .frameDone    (frame_done),
    .frameRestart (frame_restart),
    .busy         (busy)
  );

  // Output register, handshake state and registered error pulses.
  always_ff @(posedge serialClk) begin
    if (reset) begin
      outValid_q   <= 1'b0;
      sa_q         <= '0;
      cml_q        <= '0;
      frameError_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      outValid_q   <= outValid_d;
      sa_q         <= sa_d;
      cml_q        <= cml_d;
      frameError_q <= frameError_d;
      overrun_q    <= overrun_d;
    end
  end

  // Load a finished frame if the slot is free or being drained this edge; else drop it.
  always_comb begin
    outValid_d   = outValid_q;
    sa_d         = sa_q;
    cml_d        = cml_q;
    frameError_d = frame_restart;
    overrun_d    = 1'b0;
    if (frame_done) begin
      if (!outValid_q || outReady) begin
        outValid_d = 1'b1;
        sa_d       = frame_data[ACC_DATA_WIDTH-1:0];
        cml_d      = frame_data[FB-1:ACC_DATA_WIDTH];
      end else begin
        overrun_d = 1'b1;
      end
    end else if (outValid_q && outReady) begin
      outValid_d = 1'b0;
    end
  end

  assign outValid   = outValid_q;
  assign outDataSA  = sa_q;
  assign outDataCML = cml_q;
  assign frameError = frameError_q;
  assign overrun    = overrun_q;

`ifdef DESER_ERR_CNT_EN
  logic [15:0] errCount_q, errCount_d;

  // Error counter register.
  always_ff @(posedge serialClk) begin
    if (reset) begin
      errCount_q <= '0;
    end else begin
      errCount_q <= errCount_d;
    end
  end

  // Count cycles with an error pulse, saturating; clear wins over increment.
  always_comb begin
    errCount_d = errCount_q;
    if (errCountClr) begin
      errCount_d = '0;
    end else if ((frameError_q || overrun_q) && (errCount_q != 16'hFFFF)) begin
      errCount_d = errCount_q + 16'd1;
    end
  end

  assign errCount = errCount_q;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed testbench for serial_deserializer (DESER_ERR_CNT_EN adds counter tests).
module tb_serial_deserializer;

  logic        serialClk = 1'b0;
  logic        reset;
  logic        serialStart;
  logic        serialIn;
  logic        outReady;
  logic        outValid;
  logic [31:0] outDataSA;
  logic [31:0] outDataCML;
  logic        frameError;
  logic        overrun;
  logic        busy;
`ifdef DESER_ERR_CNT_EN
  logic [15:0] errCount;
  logic        errCountClr;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fe_pulses = 0;
  int ov_pulses = 0;
  int fe_base;
  int ov_base;

  always #5 serialClk = ~serialClk;

  serial_deserializer #(.ACC_DATA_WIDTH(32)) dut (
    .serialClk   (serialClk),
    .reset       (reset),
    .serialStart (serialStart),
    .serialIn    (serialIn),
    .outReady    (outReady),
    .outValid    (outValid),
    .outDataSA   (outDataSA),
    .outDataCML  (outDataCML),
    .frameError  (frameError),
    .overrun     (overrun),
    .busy        (busy)
`ifdef DESER_ERR_CNT_EN
    ,
    .errCount    (errCount),
    .errCountClr (errCountClr)
`endif
  );

  // Count error pulses away from the active edge.
  always @(negedge serialClk) begin
    if (frameError === 1'b1) fe_pulses++;
    if (overrun === 1'b1) ov_pulses++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge serialClk);
    #1;
  endtask

  // Send a full frame LSB first; optionally raise outReady on the last bit and
  // check the output is still empty-side one cycle before completion.
  task automatic send_frame(input logic [31:0] sa, input logic [31:0] cml,
                            input bit rdy_last, input bit chk_latency);
    logic [63:0] f;
    f = {cml, sa};
    for (int k = 0; k < 64; k++) begin
      serialStart = (k == 0);
      serialIn    = f[k];
      if (k == 63) begin
        if (rdy_last) outReady = 1'b1;
        if (chk_latency) begin
          check_val("valid_before_last_bit", {63'd0, outValid}, 64'd0);
          check_val("busy_mid_frame", {63'd0, busy}, 64'd1);
        end
      end
      tick();
    end
    serialStart = 1'b0;
    serialIn    = 1'b0;
    $display("frame sent sa=%08h cml=%08h -> valid=%0b sa=%08h cml=%08h ovr=%0b",
             sa, cml, outValid, outDataSA, outDataCML, overrun);
  endtask

  // Send the first n bits (all ones) of a frame that is never finished.
  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      serialStart = (k == 0);
      serialIn    = 1'b1;
      tick();
    end
    serialStart = 1'b0;
    serialIn    = 1'b0;
    $display("partial frame sent bits=%0d busy=%0b", n, busy);
  endtask

  initial begin
    reset       = 1'b1;
    serialStart = 1'b0;
    serialIn    = 1'b0;
    outReady    = 1'b0;
`ifdef DESER_ERR_CNT_EN
    errCountClr = 1'b0;
`endif
    repeat (3) tick();

    // Reset state
    check_val("rst_valid", {63'd0, outValid}, 64'd0);
    check_val("rst_sa", {32'd0, outDataSA}, 64'd0);
    check_val("rst_cml", {32'd0, outDataCML}, 64'd0);
    check_val("rst_ferr", {63'd0, frameError}, 64'd0);
    check_val("rst_ovr", {63'd0, overrun}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
`ifdef DESER_ERR_CNT_EN
    check_val("rst_errcnt", {48'd0, errCount}, 64'd0);
`endif
    reset = 1'b0;
    tick();

    // Single frame
    outReady = 1'b1;
    fe_base  = fe_pulses;
    send_frame(32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1);
    check_val("single_valid", {63'd0, outValid}, 64'd1);
    check_val("single_sa", {32'd0, outDataSA}, 64'hDEADBEEF);
    check_val("single_cml", {32'd0, outDataCML}, 64'h12345678);
    check_val("single_busy_done", {63'd0, busy}, 64'd0);
    check_val("single_ferr", {63'd0, frameError}, 64'd0);
    tick();
    check_val("single_consumed", {63'd0, outValid}, 64'd0);
    check_val("single_no_ferr_pulse", 64'(fe_pulses - fe_base), 64'd0);

    // Back-pressure: A retained, B dropped with one overrun pulse
    outReady = 1'b0;
    ov_base  = ov_pulses;
    send_frame(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    tick();
    tick();
    send_frame(32'h33333333, 32'h44444444, 1'b0, 1'b0);
    check_val("bp_ovr_pulse", {63'd0, overrun}, 64'd1);
    check_val("bp_valid", {63'd0, outValid}, 64'd1);
    check_val("bp_sa_kept", {32'd0, outDataSA}, 64'h11111111);
    check_val("bp_cml_kept", {32'd0, outDataCML}, 64'h22222222);
    tick();
    check_val("bp_ovr_one_cycle", {63'd0, overrun}, 64'd0);
    check_val("bp_ovr_count", 64'(ov_pulses - ov_base), 64'd1);
    check_val("bp_still_a", {32'd0, outDataSA}, 64'h11111111);
    outReady = 1'b1;
    tick();
    check_val("bp_consumed", {63'd0, outValid}, 64'd0);

    // Same-edge accept with zero-gap frames
    outReady = 1'b0;
    ov_base  = ov_pulses;
    send_frame(32'hAAAA0001, 32'hBBBB0002, 1'b0, 1'b0);
    send_frame(32'hCCCC0003, 32'hDDDD0004, 1'b1, 1'b0);
    check_val("same_valid", {63'd0, outValid}, 64'd1);
    check_val("same_sa", {32'd0, outDataSA}, 64'hCCCC0003);
    check_val("same_cml", {32'd0, outDataCML}, 64'hDDDD0004);
    check_val("same_no_ovr", {63'd0, overrun}, 64'd0);
    tick();
    check_val("same_ovr_count", 64'(ov_pulses - ov_base), 64'd0);
    check_val("same_consumed", {63'd0, outValid}, 64'd0);

    // Restart at bit 20
    outReady = 1'b0;
    fe_base  = fe_pulses;
    send_partial(20);
    send_frame(32'h0000FFFF, 32'hA5A5A5A5, 1'b0, 1'b0);
    check_val("restart_ferr_count", 64'(fe_pulses - fe_base), 64'd1);
    check_val("restart_valid", {63'd0, outValid}, 64'd1);
    check_val("restart_sa", {32'd0, outDataSA}, 64'h0000FFFF);
    check_val("restart_cml", {32'd0, outDataCML}, 64'hA5A5A5A5);

    // Reset mid-frame at bit 40 while output is occupied
    fe_base = fe_pulses;
    ov_base = ov_pulses;
    send_partial(40);
    reset = 1'b1;
    tick();
    check_val("mrst_valid", {63'd0, outValid}, 64'd0);
    check_val("mrst_sa", {32'd0, outDataSA}, 64'd0);
    check_val("mrst_cml", {32'd0, outDataCML}, 64'd0);
    check_val("mrst_busy", {63'd0, busy}, 64'd0);
    check_val("mrst_ferr", {63'd0, frameError}, 64'd0);
    check_val("mrst_ovr", {63'd0, overrun}, 64'd0);
    reset = 1'b0;
    tick();
    check_val("mrst_no_pulses", 64'(fe_pulses - fe_base + ov_pulses - ov_base), 64'd0);
    outReady = 1'b1;
    send_frame(32'h5A5A5A5A, 32'hC3C3C3C3, 1'b0, 1'b0);
    check_val("post_rst_valid", {63'd0, outValid}, 64'd1);
    check_val("post_rst_sa", {32'd0, outDataSA}, 64'h5A5A5A5A);
    check_val("post_rst_cml", {32'd0, outDataCML}, 64'hC3C3C3C3);
    tick();

`ifdef DESER_ERR_CNT_EN
    // Error counter: 3 restarts + 2 overruns, clear, saturation
    errCountClr = 1'b1;
    tick();
    errCountClr = 1'b0;
    check_val("cnt_cleared0", {48'd0, errCount}, 64'd0);
    outReady = 1'b0;
    send_partial(5);
    send_partial(5);
    send_partial(5);
    send_frame(32'h01010101, 32'h02020202, 1'b0, 1'b0);
    send_frame(32'h03030303, 32'h04040404, 1'b0, 1'b0);
    send_frame(32'h05050505, 32'h06060606, 1'b0, 1'b0);
    tick();
    tick();
    check_val("cnt_five", {48'd0, errCount}, 64'd5);
    errCountClr = 1'b1;
    tick();
    errCountClr = 1'b0;
    check_val("cnt_clr", {48'd0, errCount}, 64'd0);
    force dut.errCount_q = 16'hFFFE;
    #1;
    release dut.errCount_q;
    send_partial(3);
    send_partial(3);
    send_partial(3);
    send_partial(3);
    tick();
    tick();
    check_val("cnt_saturate", {48'd0, errCount}, 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
